bk_mouse_port: RTL
==================

# bk_mouse_port

Converts MiSTer PS/2 mouse packets into the BK-0011M parallel-port mouse state word. It sits directly upstream of the top-level port-read mux, which selects between joystick and mouse data, and of the port write decode at 177714. Per-axis signed motion is accumulated, and one direction bit per axis is latched when accumulated travel crosses a threshold. The block also tracks buttons and arbitrates between mouse and joystick as the port source.

## Interface
Parameters:
- THRESH, 4: travel magnitude, in counts, that latches a direction bit.
- ACC_W, 10: signed accumulator width per axis; values saturate.

Ports:
- clk_sys  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; driven from bus_reset.
- ps2_mouse  in  25  hps_io mouse word:
  - [24] packet toggle.
  - [23:16] dy magnitude byte, [5] dy sign.
  - [15:8] dx magnitude byte, [4] dx sign.
  - [1] right button, [0] left button.
- bus_wr  in  1  level write strobe, equal to port_write & bus_wtbt[0].
- bus_din  in  16  CPU write data.
- joy_active  in  1  any joystick bit set.
- mouse_state  out  7  port word:
  - [6] right, [5] left, [4] 0.
  - [3] left-move, [2] down, [1] right-move, [0] up.
- mouse_sel  out  1  1 selects mouse_state as port read data, 0 selects joystick.

## Operation
- **Packet event:** the first posedge where ps2_mouse[24] differs from its registered copy.
  - After reset the registered copy is loaded on the first cycle without generating an event (primed flag), so there is no spurious event.
- **Write event:** the first posedge where bus_wr=1 and its registered copy is 0.
  - bus_din[3]=1: enable<=1.
  - bus_din[3]=0: enable<=0, mouse_state[3:0]<=0, both accumulators<=0.
- **On every packet event:**
  - mouse_state[6:5] <= {ps2_mouse[1], ps2_mouse[0]}.
  - mouse_sel<=1.
- **Per axis, while enable=1:**
  - acc <= sat(acc + sext({sign, byte})), where sat clamps to ±(2^(ACC_W-1)-1).
  - The delta is 9-bit two's complement (range -256..255).
- **Per-axis state machine (sub-module bk_axis_acc):**
  - IDLE: both direction bits of the axis are 0. If the new acc ≥ +THRESH, set the positive bit (up for Y, right for X) and acc -= THRESH. If the new acc ≤ -THRESH, set the negative bit and acc += THRESH. Either case moves to LATCHED.
  - LATCHED: accumulation continues, saturating. No new bit is set. Returns to IDLE only via a write event with bus_din[3]=0.
  - Y uses bits 0/2. X uses bits 1/3.
  - A dx and dy crossing in the same packet latch both axes.
- **enable=0:** accumulators are held at 0. Packets still update buttons and mouse_sel.
- **Arbitration:**
  - joy_active=1 forces mouse_sel<=0.
  - If joy_active=1 coincides with a packet event, mouse_sel<=1 (packet wins).
- **Write and packet on the same edge:**
  - The write wins for enable, mouse_state[3:0] and the accumulators.
  - The packet's deltas are discarded.
  - The packet's buttons and mouse_sel updates still apply.

## Timing
- Reset values: mouse_state=0, mouse_sel=0, enable=0, accumulators 0, both axes IDLE, primed=0.
- Reset mid-operation: all state is cleared immediately (async). Events on the reset-release edge are ignored.
- Latency: mouse_state and mouse_sel reflect a packet event or write event at the output one cycle after the posedge that detects the event. The outputs are registers.
- Back-to-back packets on consecutive cycles are each processed. No buffering is required because each toggle change is one event.
- A bus_wr held high produces exactly one write event.

## Structure
- Package bk_mouse_pkg holds:
  - bit index constants MS_UP=0, MS_RIGHT=1, MS_DOWN=2, MS_LEFT=3, MS_LBTN=5, MS_RBTN=6, MS_EN_BIT=3.
  - axis state enum {AX_IDLE, AX_LATCHED}.
  - the saturating-add function.
- Sub-module bk_axis_acc (delta in, clear, enable, event → pos/neg bits) is instantiated twice, for X and Y.
- The top of the block holds edge detection, priming, button/sel logic and the write decode.

## Test plan
- **Reset priming:** hold ps2_mouse[24]=1 through reset release → no packet event, mouse_state=0, mouse_sel=0.
- **Enable and up-move:** write 0x0008, then send a packet with dy=+3 → bits[3:0]=0. Send a second packet with dy=+2 → bit0=1, Y acc=1.
- **Left-move and latch hold:** enable, send dx=-4 (sign=1, byte=0xFC) → bit3=1. Send a further dx=-10 → no change to bit1 or bit3. Write 0x0000 → bits[3:0]=0.
- **Write/packet collision:** on one edge, write 0x0000 and send a packet with dy=+50, buttons=2'b11 → bits[3:0]=0, accumulators 0, bits[6:5]=2'b11.
- **Arbitration:** after a packet sets mouse_sel=1, assert joy_active → mouse_sel=0 next cycle. Assert joy_active together with a packet → mouse_sel=1.
- **Saturation:** enable, then send 4 packets of dy=+255 (byte=0xFF, sign=0) → bit0=1 and Y acc clamped at 511.

Source files
------------

// File: rtl/bk_mouse_pkg.sv
// Shared constants, axis state type and saturating add for the BK-0011M mouse port.
package bk_mouse_pkg;

    localparam int unsigned PS2_W   = 25;
    localparam int unsigned DIN_W   = 16;
    localparam int unsigned MS_W    = 7;
    localparam int unsigned DELTA_W = 9;

    // hps_io mouse word fields
    localparam int unsigned PS2_TOG     = 24;
    localparam int unsigned PS2_DY_SIGN = 5;
    localparam int unsigned PS2_DX_SIGN = 4;
    localparam int unsigned PS2_RBTN    = 1;
    localparam int unsigned PS2_LBTN    = 0;

    // mouse_state bit positions
    localparam int unsigned MS_UP     = 0;
    localparam int unsigned MS_RIGHT  = 1;
    localparam int unsigned MS_DOWN   = 2;
    localparam int unsigned MS_LEFT   = 3;
    localparam int unsigned MS_LBTN   = 5;
    localparam int unsigned MS_RBTN   = 6;
    localparam int unsigned MS_EN_BIT = 3;

    typedef enum logic {
        AX_IDLE,
        AX_LATCHED
    } ax_state_e;

    // a + d clamped to +/-(2^(w-1)-1)
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] d,
                                                   input int unsigned w);
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        lim = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        sum = a + d;
        if (sum > lim) return lim;
        if (sum < -lim) return -lim;
        return sum;
    endfunction

endpackage

// File: rtl/bk_mouse_if.sv
// Mouse port signal bundle: PS/2 word, CPU write strobe, joystick activity and port outputs.
interface bk_mouse_if import bk_mouse_pkg::*;;
    logic [PS2_W-1:0] ps2_mouse;
    logic             bus_wr;
    logic [DIN_W-1:0] bus_din;
    logic             joy_active;
    logic [MS_W-1:0]  mouse_state;
    logic             mouse_sel;

    modport master (
        output ps2_mouse, bus_wr, bus_din, joy_active,
        input  mouse_state, mouse_sel
    );

    modport slave (
        input  ps2_mouse, bus_wr, bus_din, joy_active,
        output mouse_state, mouse_sel
    );
endinterface

// File: rtl/bk_axis_acc.sv
// One mouse axis: saturating motion accumulator and one-shot direction latch.
module bk_axis_acc import bk_mouse_pkg::*; #(
    parameter int          THRESH = 4,
    parameter int unsigned ACC_W  = 10
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic signed [DELTA_W-1:0] delta,
    input  logic                      acc_en,
    input  logic                      clear,
    output logic                      pos_q,
    output logic                      neg_q
);

    ax_state_e               state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    pos_d, neg_d;
    logic signed [31:0]      sum_c;

    // Next state: clear wins, otherwise accumulate and latch on the first threshold crossing
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        sum_c   = sat_add(32'(acc_q), 32'(delta), ACC_W);
        if (clear) begin
            state_d = AX_IDLE;
            acc_d   = '0;
            pos_d   = 1'b0;
            neg_d   = 1'b0;
        end else if (acc_en) begin
            case (state_q)
                AX_IDLE: begin
                    if (sum_c >= THRESH) begin
                        pos_d   = 1'b1;
                        acc_d   = ACC_W'(sum_c - THRESH);
                        state_d = AX_LATCHED;
                    end else if (sum_c <= -THRESH) begin
                        neg_d   = 1'b1;
                        acc_d   = ACC_W'(sum_c + THRESH);
                        state_d = AX_LATCHED;
                    end else begin
                        acc_d   = ACC_W'(sum_c);
                    end
                end
                AX_LATCHED: acc_d = ACC_W'(sum_c);
            endcase
        end
    end

    // Axis state registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= AX_IDLE;
            acc_q   <= '0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: rtl/bk_mouse_port.sv
// BK-0011M parallel-port mouse: PS/2 packet decode, port write decode and mouse/joystick arbitration.
module bk_mouse_port import bk_mouse_pkg::*; #(
    parameter int          THRESH = 4,
    parameter int unsigned ACC_W  = 10
) (
    input  logic         clk_sys,
    input  logic         reset,
    bk_mouse_if.slave    bus
);

    logic                      primed_q, primed_d;
    logic                      tog_q, tog_d;
    logic                      wr_q, wr_d;
    logic                      enable_q, enable_d;
    logic                      sel_q, sel_d;
    logic [1:0]                btn_q, btn_d;

    logic                      pkt_evt_c, wr_evt_c, clear_c, acc_en_c;
    logic signed [DELTA_W-1:0] dx_c, dy_c;
    logic                      x_pos, x_neg, y_pos, y_neg;
    logic                      unused_c;

    assign dy_c = {bus.ps2_mouse[PS2_DY_SIGN], bus.ps2_mouse[23:16]};
    assign dx_c = {bus.ps2_mouse[PS2_DX_SIGN], bus.ps2_mouse[15:8]};

    // Fields of the input words this port does not look at
    assign unused_c = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2],
                        bus.bus_din[DIN_W-1:4], bus.bus_din[2:0]};

    // Event detection, write decode, buttons and source select
    always_comb begin
        pkt_evt_c = primed_q & (bus.ps2_mouse[PS2_TOG] ^ tog_q);
        wr_evt_c  = primed_q & bus.bus_wr & ~wr_q;
        clear_c   = wr_evt_c & ~bus.bus_din[MS_EN_BIT];
        acc_en_c  = enable_q & pkt_evt_c & ~wr_evt_c;

        primed_d  = 1'b1;
        tog_d     = bus.ps2_mouse[PS2_TOG];
        wr_d      = bus.bus_wr;
        enable_d  = enable_q;
        sel_d     = sel_q;
        btn_d     = btn_q;

        if (wr_evt_c) enable_d = bus.bus_din[MS_EN_BIT];

        if (pkt_evt_c) begin
            btn_d = {bus.ps2_mouse[PS2_RBTN], bus.ps2_mouse[PS2_LBTN]};
            sel_d = 1'b1;
        end else if (bus.joy_active) begin
            sel_d = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed_q <= 1'b0;
            tog_q    <= 1'b0;
            wr_q     <= 1'b0;
            enable_q <= 1'b0;
            sel_q    <= 1'b0;
            btn_q    <= 2'b00;
        end else begin
            primed_q <= primed_d;
            tog_q    <= tog_d;
            wr_q     <= wr_d;
            enable_q <= enable_d;
            sel_q    <= sel_d;
            btn_q    <= btn_d;
        end
    end

    bk_axis_acc #(.THRESH(THRESH), .ACC_W(ACC_W)) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (reset),
        .delta   (dx_c),
        .acc_en  (acc_en_c),
        .clear   (clear_c),
        .pos_q   (x_pos),
        .neg_q   (x_neg)
    );

    bk_axis_acc #(.THRESH(THRESH), .ACC_W(ACC_W)) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (reset),
        .delta   (dy_c),
        .acc_en  (acc_en_c),
        .clear   (clear_c),
        .pos_q   (y_pos),
        .neg_q   (y_neg)
    );

    // Port word assembled directly from registers
    always_comb begin
        bus.mouse_state          = '0;
        bus.mouse_state[MS_UP]    = y_pos;
        bus.mouse_state[MS_RIGHT] = x_pos;
        bus.mouse_state[MS_DOWN]  = y_neg;
        bus.mouse_state[MS_LEFT]  = x_neg;
        bus.mouse_state[MS_LBTN]  = btn_q[0];
        bus.mouse_state[MS_RBTN]  = btn_q[1];
    end

    assign bus.mouse_sel = sel_q;

endmodule
